// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between instruction fetch
// and the MEM stage, with a programmable number of wait states per access.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              stall_req_o
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    // last_grant doubles as the owner of the access in flight: 0 = IF, 1 = MEM
    logic              last_grant, last_grant_nxt;
    logic              grant_mem;

    logic              bus_ce_nxt;
    logic              bus_we_nxt;
    logic [ADDR_W-1:0] bus_addr_nxt;
    logic [DATA_W-1:0] bus_wdata_nxt;
    logic [DATA_W-1:0] if_rdata_nxt;
    logic [DATA_W-1:0] mem_rdata_nxt;
    logic              if_ack_nxt;
    logic              mem_ack_nxt;

    // On a tie MEM wins unless it was the previous owner.
    assign grant_mem = mem_req_i & (~if_req_i | ~last_grant);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        bus_ce_nxt     = 1'b0;
        bus_we_nxt     = 1'b0;
        bus_addr_nxt   = bus_addr_o;
        bus_wdata_nxt  = bus_wdata_o;
        if_rdata_nxt   = if_rdata_o;
        mem_rdata_nxt  = mem_rdata_o;
        if_ack_nxt     = 1'b0;
        mem_ack_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (if_req_i || mem_req_i) begin
                    state_nxt      = ACCESS;
                    cnt_nxt        = CNT_LOAD;
                    last_grant_nxt = grant_mem;
                    bus_ce_nxt     = 1'b1;
                    if (grant_mem) begin
                        bus_we_nxt    = mem_we_i;
                        bus_addr_nxt  = mem_addr_i;
                        bus_wdata_nxt = mem_wdata_i;
                    end else begin
                        bus_we_nxt    = 1'b0;
                        bus_addr_nxt  = if_addr_i;
                        bus_wdata_nxt = '0;
                    end
                end
            end

            ACCESS: begin
                bus_ce_nxt = 1'b1;
                bus_we_nxt = bus_we_o;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt  = RESP;
                    bus_ce_nxt = 1'b0;
                    bus_we_nxt = 1'b0;
                    if (!bus_we_o) begin
                        if (last_grant) begin
                            mem_rdata_nxt = bus_rdata_i;
                        end else begin
                            if_rdata_nxt = bus_rdata_i;
                        end
                    end
                    if_ack_nxt  = ~last_grant;
                    mem_ack_nxt = last_grant;
                end
            end

            // Requests are deliberately ignored here: a requester may still be
            // dropping its request on this edge.
            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            last_grant  <= 1'b0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_grant  <= last_grant_nxt;
            bus_ce_o    <= bus_ce_nxt;
            bus_we_o    <= bus_we_nxt;
            bus_addr_o  <= bus_addr_nxt;
            bus_wdata_o <= bus_wdata_nxt;
            if_rdata_o  <= if_rdata_nxt;
            mem_rdata_o <= mem_rdata_nxt;
            if_ack_o    <= if_ack_nxt;
            mem_ack_o   <= mem_ack_nxt;
        end
    end

    // Low in the ack cycle so the pipeline advances on that edge.
    assign stall_req_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: cycle-level transaction model for the WAIT_CYCLES=1
// instance, plus directed literal expectations on WAIT_CYCLES=1, 0 and 3 instances.
module tb_mem_bus_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;

    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_ce, bus_we, stall;

    logic        a0_req = 1'b0, a3_req = 1'b0, zero_bit = 1'b0;
    logic [31:0] aux_addr = '0, zero_word = '0;
    logic [31:0] a0_if_rdata, a0_mem_rdata, a0_addr, a0_wdata;
    logic        a0_if_ack, a0_mem_ack, a0_ce, a0_we, a0_stall;
    logic [31:0] a3_if_rdata, a3_mem_rdata, a3_addr, a3_wdata;
    logic        a3_if_ack, a3_mem_ack, a3_ce, a3_we, a3_stall;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .bus_ce_o(bus_ce), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .stall_req_o(stall)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst),
        .if_req_i(a0_req), .if_addr_i(aux_addr), .if_rdata_o(a0_if_rdata), .if_ack_o(a0_if_ack),
        .mem_req_i(zero_bit), .mem_we_i(zero_bit), .mem_addr_i(zero_word),
        .mem_wdata_i(zero_word), .mem_rdata_o(a0_mem_rdata), .mem_ack_o(a0_mem_ack),
        .bus_ce_o(a0_ce), .bus_we_o(a0_we), .bus_addr_o(a0_addr),
        .bus_wdata_o(a0_wdata), .bus_rdata_i(bus_rdata), .stall_req_o(a0_stall)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst),
        .if_req_i(a3_req), .if_addr_i(aux_addr), .if_rdata_o(a3_if_rdata), .if_ack_o(a3_if_ack),
        .mem_req_i(zero_bit), .mem_we_i(zero_bit), .mem_addr_i(zero_word),
        .mem_wdata_i(zero_word), .mem_rdata_o(a3_mem_rdata), .mem_ack_o(a3_mem_ack),
        .bus_ce_o(a3_ce), .bus_we_o(a3_we), .bus_addr_o(a3_addr),
        .bus_wdata_o(a3_wdata), .bus_rdata_i(bus_rdata), .stall_req_o(a3_stall)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // signal ids: +0 ce, +1 we, +2 addr, +3 wdata, +4 if_ack, +5 if_rdata,
    // +6 mem_ack, +7 mem_rdata, +8 stall; base 0 main, 10 w0, 20 w3
    localparam int S_CE = 0, S_WE = 1, S_ADDR = 2, S_WDATA = 3, S_IFACK = 4;
    localparam int S_IFRD = 5, S_MACK = 6, S_MRD = 7, S_STALL = 8;

    function automatic logic [31:0] get_sig(int id);
        case (id)
            0:  return 32'(bus_ce);
            1:  return 32'(bus_we);
            2:  return bus_addr;
            3:  return bus_wdata;
            4:  return 32'(if_ack);
            5:  return if_rdata;
            6:  return 32'(mem_ack);
            7:  return mem_rdata;
            8:  return 32'(stall);
            10: return 32'(a0_ce);
            11: return 32'(a0_we);
            12: return a0_addr;
            13: return a0_wdata;
            14: return 32'(a0_if_ack);
            15: return a0_if_rdata;
            16: return 32'(a0_mem_ack);
            17: return a0_mem_rdata;
            18: return 32'(a0_stall);
            20: return 32'(a3_ce);
            21: return 32'(a3_we);
            22: return a3_addr;
            23: return a3_wdata;
            24: return 32'(a3_if_ack);
            25: return a3_if_rdata;
            26: return 32'(a3_mem_ack);
            27: return a3_mem_rdata;
            28: return 32'(a3_stall);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string sig_name(int id);
        string nm [9] = '{"bus_ce", "bus_we", "bus_addr", "bus_wdata", "if_ack",
                          "if_rdata", "mem_ack", "mem_rdata", "stall"};
        string pre;
        pre = (id >= 20) ? "w3_" : (id >= 10) ? "w0_" : "";
        return {pre, nm[id % 10]};
    endfunction

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
    } lit_t;
    lit_t lits[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // transaction-level model of the WAIT_CYCLES=1 instance
    bit          m_valid = 0, m_act = 0, m_own = 0, m_we = 0, m_last = 0;
    int          m_s = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_mem_rd = '0;
    bit          e_acc, e_ack, e_if_ack, e_mem_ack;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            e_acc     = m_act && (cyc >= m_s + 1) && (cyc <= m_s + 1 + W);
            e_ack     = m_act && (cyc == m_s + 2 + W);
            e_if_ack  = e_ack && !m_own;
            e_mem_ack = e_ack && m_own;
            chk("bus_ce",    32'(bus_ce),  32'(e_acc));
            chk("bus_we",    32'(bus_we),  32'(e_acc && m_we));
            chk("bus_addr",  bus_addr,     m_addr);
            chk("bus_wdata", bus_wdata,    m_wdata);
            chk("if_ack",    32'(if_ack),  32'(e_if_ack));
            chk("mem_ack",   32'(mem_ack), 32'(e_mem_ack));
            chk("if_rdata",  if_rdata,     m_if_rd);
            chk("mem_rdata", mem_rdata,    m_mem_rd);
            chk("stall",     32'(stall),
                32'((if_req && !e_if_ack) || (mem_req && !e_mem_ack)));
            foreach (lits[i]) begin
                if (lits[i].at == cyc)
                    chk({"lit_", sig_name(lits[i].sig)}, get_sig(lits[i].sig), lits[i].val);
            end
            if (e_acc && cyc == m_s + 1 + W && !m_we) begin
                if (m_own) m_mem_rd = bus_rdata;
                else       m_if_rd  = bus_rdata;
            end
        end
        if (rst) begin
            m_valid = 1; m_act = 0; m_last = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0;
        end else if (m_valid) begin
            if (e_ack) begin
                m_act = 0;
            end else if (!m_act && (if_req || mem_req)) begin
                m_own   = (mem_req && if_req) ? !m_last : mem_req;
                m_last  = m_own;
                m_act   = 1;
                m_s     = cyc;
                m_we    = m_own ? mem_we : 1'b0;
                m_addr  = m_own ? mem_addr : if_addr;
                m_wdata = m_own ? mem_wdata : 32'h0;
            end
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            bus_rdata = 32'hC0DE_0000 | 32'(cyc);
        end
    endtask

    task automatic lit(input int at, input int sig, input logic [31:0] val);
        lits.push_back('{at, sig, val});
    endtask

    initial begin
        // reset, IF read at cycle 2
        lit(1, S_CE, 0);   lit(1, S_IFRD, 0); lit(1, S_ADDR, 0);  lit(2, S_STALL, 1);
        lit(3, S_CE, 1);   lit(3, S_WE, 0);   lit(3, S_ADDR, 32'h10); lit(4, S_CE, 1);
        lit(4, S_STALL, 1); lit(5, S_IFACK, 1); lit(5, S_IFRD, 32'h3C01ABCD);
        lit(5, S_STALL, 0); lit(5, S_CE, 0);  lit(6, S_IFACK, 0);
        // MEM store
        lit(9, S_WE, 1);   lit(9, S_ADDR, 32'h100);  lit(9, S_WDATA, 32'hDEADBEEF);
        lit(10, S_WE, 1);  lit(10, S_ADDR, 32'h100); lit(10, S_WDATA, 32'hDEADBEEF);
        lit(11, S_MACK, 1); lit(11, S_MRD, 0); lit(11, S_WE, 0); lit(11, S_CE, 0);
        lit(11, S_IFRD, 32'h3C01ABCD);
        // both requesting from reset: MEM, IF, MEM, IF, MEM
        lit(17, S_ADDR, 32'h200); lit(17, S_WE, 0); lit(19, S_MACK, 1); lit(19, S_IFACK, 0);
        lit(19, S_MRD, 32'hC0DE0012); lit(21, S_ADDR, 32'h004); lit(23, S_IFACK, 1);
        lit(23, S_MACK, 0); lit(23, S_IFRD, 32'hC0DE0016); lit(25, S_WE, 1);
        lit(25, S_ADDR, 32'h204); lit(25, S_WDATA, 32'hA5A5A5A5); lit(27, S_MACK, 1);
        lit(27, S_MRD, 32'hC0DE0012); lit(29, S_ADDR, 32'h008); lit(31, S_IFRD, 32'hC0DE001E);
        // reset in 2nd ACCESS cycle of a store, then re-serve
        lit(41, S_MRD, 32'hC0DE0012); lit(41, S_WE, 1); lit(42, S_CE, 1);
        lit(43, S_CE, 0); lit(43, S_MACK, 0); lit(43, S_ADDR, 0); lit(43, S_WDATA, 0);
        lit(43, S_MRD, 0); lit(43, S_IFRD, 0); lit(44, S_CE, 1); lit(44, S_ADDR, 32'h300);
        lit(46, S_MACK, 1); lit(46, S_MRD, 0);
        // request held past ack; new grant only from IDLE
        lit(53, S_IFACK, 1); lit(53, S_IFRD, 32'hC0DE0034); lit(54, S_CE, 0);
        lit(54, S_IFACK, 0); lit(55, S_CE, 1); lit(55, S_ADDR, 32'h40); lit(55, S_STALL, 0);
        lit(57, S_IFACK, 1); lit(57, S_IFRD, 32'hC0DE0038); lit(58, S_CE, 0);
        lit(63, S_MACK, 1); lit(63, S_MRD, 32'hC0DE003E); lit(64, S_STALL, 0); lit(65, S_CE, 0);
        // WAIT_CYCLES = 0 and 3
        lit(71, 10 + S_CE, 1); lit(72, 10 + S_CE, 0); lit(72, 10 + S_IFACK, 1);
        lit(72, 10 + S_IFRD, 32'hC0DE0047); lit(73, 10 + S_IFACK, 0); lit(71, 10 + S_ADDR, 32'h8);
        lit(71, 20 + S_CE, 1); lit(74, 20 + S_CE, 1); lit(72, 20 + S_STALL, 1);
        lit(74, 20 + S_IFACK, 0); lit(75, 20 + S_IFACK, 1); lit(75, 20 + S_CE, 0);
        lit(75, 20 + S_IFRD, 32'hC0DE004A); lit(76, 20 + S_IFACK, 0);

        goto(2);
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h10;
        goto(3); bus_rdata = 32'h1111_1111;
        goto(4); bus_rdata = 32'h3C01_ABCD;
        goto(6); if_req = 1'b0;

        goto(8);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF;
        goto(12); mem_req = 1'b0;

        goto(14);
        rst = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_wdata = '0;
        if_req = 1'b1; if_addr = 32'h004;
        goto(16); rst = 1'b0;
        goto(20); mem_we = 1'b1; mem_addr = 32'h204; mem_wdata = 32'hA5A5A5A5;
        goto(24); if_addr = 32'h008;
        goto(32); if_req = 1'b0;
        goto(36); mem_req = 1'b0;

        goto(40);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h12345678;
        goto(42); rst = 1'b1;
        goto(43); rst = 1'b0;
        goto(47); mem_req = 1'b0;

        goto(50); if_req = 1'b1; if_addr = 32'h40;
        goto(55); if_req = 1'b0;
        goto(60); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
        goto(64); mem_req = 1'b0;

        goto(70); a0_req = 1'b1; a3_req = 1'b1; aux_addr = 32'h8;
        goto(73); a0_req = 1'b0;
        goto(76); a3_req = 1'b0;

        goto(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-port unified memory between instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sequences each access with a programmable number of wait states.
- Returns read data and a one-cycle ack to the granted requester.
- Raises a stall request to the pipeline controller while any request is outstanding.
- Sits between the IF/MEM stages and the RAM.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
WAIT_CYCLES, 1, extra RAM cycles per access (0 legal); bus held WAIT_CYCLES+1 cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
if_req_i  in  1  IF read request, level, held until if_ack_o
if_addr_i  in  ADDR_W  IF address
if_rdata_o  out  DATA_W  IF read data, registered, valid when if_ack_o
if_ack_o  out  1  IF completion pulse
mem_req_i  in  1  MEM request (stage chip-enable), level, held until mem_ack_o
mem_we_i  in  1  1=store, 0=load
mem_addr_i  in  ADDR_W  MEM address
mem_wdata_i  in  DATA_W  store data
mem_rdata_o  out  DATA_W  load data, registered, valid when mem_ack_o
mem_ack_o  out  1  MEM completion pulse
bus_ce_o  out  1  RAM chip enable
bus_we_o  out  1  RAM write enable
bus_addr_o  out  ADDR_W  RAM address
bus_wdata_o  out  DATA_W  RAM write data
bus_rdata_i  in  DATA_W  RAM read data, valid in last ACCESS cycle
stall_req_o  out  1  stall request to pipeline control

Behaviour:
- Reset:
  - State goes to IDLE and the counter clears.
  - All registered outputs are 0: bus_*, *_rdata_o, *_ack_o.
  - last_grant resets to IF, so MEM wins the first tie.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - bus_ce_o=0 and bus_we_o=0.
  - If any req is high, pick an owner:
    - Only one requester asserted: that requester is granted.
    - Both asserted: grant the one that is not last_grant (round-robin).
  - On grant:
    - Latch addr, we (IF forces we=0) and wdata into bus_* registers.
    - Load cnt=WAIT_CYCLES, update last_grant, go to ACCESS.
- ACCESS:
  - bus_ce_o=1; bus_addr/we/wdata are stable for the whole state.
  - cnt>0: decrement cnt and stay in ACCESS.
  - cnt==0 on a read: capture bus_rdata_i into the owner's rdata register.
  - cnt==0 on a write: the rdata register is unchanged.
  - cnt==0: go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle; bus_ce_o=0 and bus_we_o=0.
  - Requests are not sampled for a new grant in RESP. This prevents re-serving a request the requester drops at this edge.
  - Go to IDLE.
- Latency: a request first seen in IDLE at cycle t gives ACCESS at t+1..t+1+WAIT_CYCLES and ack at t+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+3 cycles.
- stall_req_o is combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o). It is low in the ack cycle so the pipeline advances on that edge.
- Only one ack is ever high per cycle, and a non-owner's ack is never asserted.
- Fairness: both requesting continuously alternates MEM, IF, MEM, ... Neither requester waits more than two access slots.
- Request dropped before ack (protocol violation): the access still completes and ack is still issued.
- Reset mid-ACCESS:
  - The next edge goes to IDLE with bus_ce_o=0, and no ack is issued.
  - A store may be partially performed, which is acceptable.
- Reset during RESP: the ack is suppressed from the next edge on.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1 bit. WAIT_CYCLES=0 gives a single ACCESS cycle.

Test Plan:
- WAIT_CYCLES=1, IF req addr 0x00000010 at cycle 2, RAM returns 0x3C01ABCD → bus_ce_o=1 at cycles 3-4, bus_we_o=0, if_rdata_o=0x3C01ABCD and if_ack_o=1 at cycle 5, stall_req_o=1 at cycles 2-4 and 0 at cycle 5.
- MEM store addr 0x00000100, data 0xDEADBEEF → bus_we_o=1 with stable addr/data for 2 cycles, mem_ack_o pulse, mem_rdata_o unchanged (0).
- IF and MEM both asserted from reset (MEM load 0x200, IF 0x004) → MEM served first, then IF. Continuous requests alternate grants, and acks never overlap.
- WAIT_CYCLES=0 → ACCESS lasts 1 cycle and ack arrives 2 cycles after request. WAIT_CYCLES=3 → ack at t+5.
- rst asserted in the 2nd ACCESS cycle of a store → next edge bus_ce_o=0, no ack, outputs 0. After rst drops, the still-held request is re-served completely.
- Requester keeps req high for one cycle after ack → no second grant from RESP. A new grant starts from IDLE only if req is still high there.
